sv_uart_rx_assembler: RTL and testbench

Receive-side counterpart of the UART word engine: deserializes a UART line (8N1, LSB-first bits) into bytes and packs `DATA_WIDTH/8` consecutive bytes, first-received byte in the MSBs, into one AXI-Stream master word. It sits between the board `irx` pin and the wide-word consumer. It pairs with the transmit path, which sends the MSB byte of each word first. Framing errors, overflow and inter-byte timeouts are reported on single-cycle status pulses.

---
 rtl/sv_uart_pkg.sv | 29 ++
 rtl/sv_uart_rx_bit.sv | 108 ++++++++++
 rtl/sv_uart_rx_assembler.sv | 117 +++++++++++
 tb/tb_sv_uart_rx_assembler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the UART receive path.
package sv_uart_pkg;

  localparam int unsigned WORD_WIDTH  = 8;
  localparam int unsigned DIV_WIDTH   = 16;
  localparam int unsigned MIN_DIVIDER = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Per-cycle event bundle from the bit engine to the word packer.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  start;
    logic                  done;
    logic                  frame_err;
  } uart_rx_evt_t;

  // Very small dividers cannot place a mid-bit sample, so they are raised to a floor.
  function automatic logic [DIV_WIDTH-1:0] clamp_divider(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(MIN_DIVIDER)) ? DIV_WIDTH'(MIN_DIVIDER) : d;
  endfunction

endpackage

// File: rtl/sv_uart_rx_bit.sv
// UART 8N1 bit engine: input synchronizer, bit-timing FSM and byte shift register.
module sv_uart_rx_bit
  import sv_uart_pkg::*;
#(
  parameter int unsigned IN_PIPE = 3
) (
  input  logic                 iclk,
  input  logic                 irst_n,
  input  logic                 irx,
  input  logic [DIV_WIDTH-1:0] idivider,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 idle_c,
  output uart_rx_evt_t         evt_c
);

  logic [IN_PIPE-1:0]    sync_q;
  logic                  rx_s;
  logic                  rx_prev;
  uart_rx_state_t        state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [2:0]            bcnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  fall_c;
  logic                  bit_tick_c;

  assign rx_s = sync_q[IN_PIPE-1];

  // Metastability synchronizer plus one-cycle history for edge detection.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[IN_PIPE-2:0], irx};
      rx_prev <= rx_s;
    end
  end

  // Strobes decoded from the current state and phase counter.
  always_comb begin
    fall_c          = rx_prev & ~rx_s;
    bit_tick_c      = (cnt == div - DIV_WIDTH'(1));
    idle_c          = (state == IDLE);
    evt_c           = '0;
    evt_c.data      = shreg;
    evt_c.start     = (state == IDLE) && fall_c;
    evt_c.done      = (state == STOP) && bit_tick_c && rx_s;
    evt_c.frame_err = (state == STOP) && bit_tick_c && !rx_s;
  end

  // Bit-timing FSM: mid-bit start check, then one sample per bit period.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state <= IDLE;
      div   <= DIV_WIDTH'(MIN_DIVIDER);
      cnt   <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall_c) begin
            div   <= clamp_divider(idivider);
            cnt   <= '0;
            bcnt  <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == (div >> 1)) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_tick_c) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[WORD_WIDTH-1:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (bit_tick_c) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              shreg <= '0;
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sv_uart_rx_assembler.sv
// Packs received UART bytes (first byte in MSBs) into AXI-Stream words with status pulses.
module sv_uart_rx_assembler
  import sv_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned IN_PIPE      = 3,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  irx,
  input  logic [15:0]           idivider,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  oframe_err,
  output logic                  oovf,
  output logic                  otimeout
);

  localparam int unsigned BYTES = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned WCW   = $clog2(BYTES);
  localparam int unsigned TCW   = $clog2(TIMEOUT_BITS * 65535 + 1);

  logic [DIV_WIDTH-1:0]  div;
  logic                  idle_c;
  uart_rx_evt_t          evt_c;
  logic [WCW-1:0]        wcnt;
  logic [DATA_WIDTH-1:0] word;
  logic [TCW-1:0]        tcnt;
  logic [TCW-1:0]        limit_c;
  logic                  running_c;
  logic                  expire_c;
  logic                  complete_c;
  logic [DATA_WIDTH-1:0] new_word_c;

  sv_uart_rx_bit #(
    .IN_PIPE (IN_PIPE)
  ) u_bit (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .irx      (irx),
    .idivider (idivider),
    .div      (div),
    .idle_c   (idle_c),
    .evt_c    (evt_c)
  );

  // Word completion and inter-byte timeout decode.
  always_comb begin
    new_word_c = {word[DATA_WIDTH-WORD_WIDTH-1:0], evt_c.data};
    complete_c = evt_c.done && (wcnt == WCW'(BYTES - 1));
    limit_c    = TCW'(TIMEOUT_BITS) * TCW'(div);
    running_c  = idle_c && (wcnt != '0);
    expire_c   = running_c && (tcnt >= limit_c - TCW'(1));
  end

  // Idle-time counter between bytes of a partial word; saturates rather than wraps.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      tcnt <= '0;
    end else if (!running_c || expire_c || evt_c.start) begin
      tcnt <= '0;
    end else if (tcnt != '1) begin
      tcnt <= tcnt + TCW'(1);
    end
  end

  // Byte packing; errors and timeouts throw away the partial word.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wcnt <= '0;
      word <= '0;
    end else if (expire_c || evt_c.frame_err) begin
      wcnt <= '0;
      word <= '0;
    end else if (evt_c.done) begin
      if (complete_c) begin
        wcnt <= '0;
        word <= '0;
      end else begin
        wcnt <= wcnt + WCW'(1);
        word <= new_word_c;
      end
    end
  end

  // Output register: loads when empty or draining, otherwise the new word is dropped.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      oovf          <= 1'b0;
    end else begin
      oovf <= 1'b0;
      if (complete_c && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= new_word_c;
        m_axis_tvalid <= 1'b1;
      end else begin
        if (complete_c) oovf <= 1'b1;
        if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Single-cycle status strobes.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oframe_err <= 1'b0;
      otimeout   <= 1'b0;
    end else begin
      oframe_err <= evt_c.frame_err;
      otimeout   <= expire_c;
    end
  end

endmodule

// File: tb/tb_sv_uart_rx_assembler.sv
// Scoreboard bench for the UART receive word assembler.
module tb_sv_uart_rx_assembler;

  localparam int unsigned DW    = 24;
  localparam int unsigned BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [15:0]   divider;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          fe, ovf, to;

  always #5 clk = ~clk;

  sv_uart_rx_assembler #(
    .DATA_WIDTH   (24),
    .IN_PIPE      (3),
    .TIMEOUT_BITS (20)
  ) dut (
    .iclk          (clk),
    .irst_n        (rst_n),
    .irx           (rx),
    .idivider      (divider),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .oframe_err    (fe),
    .oovf          (ovf),
    .otimeout      (to)
  );

  int n_chk = 0, n_fail = 0;
  int exp_fe = 0, exp_ovf = 0, exp_to = 0;
  int obs_fe = 0, obs_ovf = 0, obs_to = 0;
  int tv_run = 0, tv_max = 0;
  int last_eff = 16;
  logic [DW-1:0] exp_q[$];
  logic [7:0]    partial[$];
  bit rdy_model = 1'b0;
  bit model_full = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and counts status pulses.
  task automatic monitor();
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL word_unexpected: got %0h, required no word", tdata);
          end else begin
            w = exp_q.pop_front();
            chk("word", 64'(tdata), 64'(w));
          end
        end
        if (fe)  obs_fe++;
        if (ovf) obs_ovf++;
        if (to)  obs_to++;
        if (tvalid) tv_run++; else tv_run = 0;
        if (tv_run > tv_max) tv_max = tv_run;
      end else begin
        tv_run = 0;
      end
    end
  endtask

  // All stimulus changes land 1 ns after a rising edge.
  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ready(input bit r);
    tready    = r;
    rdy_model = r;
    if (r) model_full = 1'b0;
  endtask

  function automatic int clampd(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  // Reference model: bytes collect into a word, first byte in the MSBs.
  function automatic void model_byte(input logic [7:0] b);
    logic [DW-1:0] w;
    partial.push_back(b);
    if (partial.size() == BYTES) begin
      w = '0;
      foreach (partial[i]) w = (w << 8) | DW'(partial[i]);
      partial.delete();
      if (model_full && !rdy_model) begin
        exp_ovf++;
      end else begin
        exp_q.push_back(w);
        if (!rdy_model) model_full = 1'b1;
      end
    end
  endfunction

  function automatic void model_timeout();
    if (partial.size() != 0) begin
      exp_to++;
      partial.delete();
    end
  endfunction

  task automatic drive_bit(input logic v, input int eff);
    rx = v;
    wait_cyc(eff);
  endtask

  // One 8N1 frame followed by gap_bits idle bit periods plus extra cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap_bits,
                            input int d, input int extra);
    int eff;
    eff = clampd(d);
    if (stop_ok) model_byte(b);
    else begin
      exp_fe++;
      partial.delete();
    end
    if (gap_bits >= 20) model_timeout();
    divider  = 16'(d);
    last_eff = eff;
    drive_bit(1'b0, eff);
    for (int i = 0; i < 8; i++) drive_bit(b[i], eff);
    drive_bit(stop_ok, eff);
    rx = 1'b1;
    wait_cyc(gap_bits * eff + extra);
  endtask

  task automatic idle_long();
    model_timeout();
    wait_cyc(24 * last_eff + 20);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_err"}, 64'(obs_fe), 64'(exp_fe));
    chk({tag, "_ovf"}, 64'(obs_ovf), 64'(exp_ovf));
    chk({tag, "_timeout"}, 64'(obs_to), 64'(exp_to));
    chk({tag, "_pending_words"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    divider = 16'd16;
    tready  = 1'b0;
    fork
      monitor();
    join_none
    wait_cyc(4);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_frame_err", 64'(fe), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_timeout", 64'(to), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cyc(4);

    // Back-to-back bytes, consumer always ready.
    set_ready(1'b1);
    tv_max = 0;
    send_frame(8'hA1, 1'b1, 0, 16, 0);
    send_frame(8'hB2, 1'b1, 0, 16, 0);
    send_frame(8'hC3, 1'b1, 3, 16, 0);
    chk("tvalid_width", 64'(tv_max), 64'd1);
    check_counts("basic");

    // Stalled consumer: second word is dropped.
    set_ready(1'b0);
    send_frame(8'h01, 1'b1, 1, 16, 0);
    send_frame(8'h02, 1'b1, 1, 16, 0);
    send_frame(8'h03, 1'b1, 1, 16, 0);
    send_frame(8'h04, 1'b1, 1, 16, 0);
    send_frame(8'h05, 1'b1, 1, 16, 0);
    send_frame(8'h06, 1'b1, 2, 16, 0);
    chk("stall_data", 64'(tdata), 64'h010203);
    set_ready(1'b1);
    wait_cyc(4);
    send_frame(8'h07, 1'b1, 1, 16, 0);
    send_frame(8'h08, 1'b1, 1, 16, 0);
    send_frame(8'h09, 1'b1, 3, 16, 0);
    check_counts("overflow");

    // Framing error discards the partial word.
    send_frame(8'h11, 1'b1, 1, 16, 0);
    send_frame(8'h5A, 1'b0, 2, 16, 0);
    send_frame(8'h22, 1'b1, 1, 16, 0);
    send_frame(8'h33, 1'b1, 1, 16, 0);
    send_frame(8'h44, 1'b1, 3, 16, 0);
    check_counts("frame");

    // Inter-byte timeout.
    send_frame(8'h55, 1'b1, 1, 16, 0);
    send_frame(8'h66, 1'b1, 22, 16, 0);
    chk("timeout_tvalid", 64'(tvalid), 64'd0);
    send_frame(8'h77, 1'b1, 1, 16, 0);
    send_frame(8'h88, 1'b1, 1, 16, 0);
    send_frame(8'h99, 1'b1, 3, 16, 0);
    check_counts("timeout");

    // Short low glitch on the line.
    divider = 16'd16;
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(80);
    chk("glitch_tvalid", 64'(tvalid), 64'd0);
    check_counts("glitch");

    // Reset in the middle of a frame while a word is held.
    set_ready(1'b0);
    send_frame(8'h31, 1'b1, 1, 16, 0);
    send_frame(8'h32, 1'b1, 1, 16, 0);
    send_frame(8'h33, 1'b1, 2, 16, 0);
    chk("held_tvalid", 64'(tvalid), 64'd1);
    send_frame(8'h12, 1'b1, 1, 16, 0);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(tvalid), 64'd0);
    chk("async_rst_tdata", 64'(tdata), 64'd0);
    exp_q.delete();
    partial.delete();
    model_full = 1'b0;
    rx = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    set_ready(1'b1);
    wait_cyc(3);
    send_frame(8'hDE, 1'b1, 1, 16, 0);
    send_frame(8'hAD, 1'b1, 1, 16, 0);
    send_frame(8'hBE, 1'b1, 3, 16, 0);
    check_counts("reset");

    // Randomised frames, dividers (including clamped ones), errors and gaps.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit ok;
      bit lng;
      int d;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      lng = ($urandom_range(0, 5) == 0);
      d   = $urandom_range(0, 24);
      send_frame(b, ok, lng ? 22 : $urandom_range(1, 4), d, $urandom_range(0, 3));
    end
    idle_long();
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
